// File: rtl/match_scoreboard_pkg.sv
// Shared encodings, state type and helpers for the match scoreboard.
// Imported by the top and by the history FIFO.
package match_pkg;

  localparam logic [1:0] WHO_NONE   = 2'b00;
  localparam logic [1:0] WHO_LOSER  = 2'b01;
  localparam logic [1:0] WHO_WINNER = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // A history entry is the round index plus one result bit.
  function automatic int unsigned hist_entry_w(input int unsigned idx_w);
    return idx_w + 32'd1;
  endfunction

  function automatic logic who_is_valid(input logic [1:0] who);
    return (who == WHO_LOSER) || (who == WHO_WINNER);
  endfunction

endpackage

// File: rtl/match_scoreboard_hist_fifo.sv
// Show-ahead history FIFO: head visible whenever non-empty, simultaneous
// push/pop always succeed, a push into a full FIFO without a pop is dropped.
module hist_fifo
  import match_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             drop_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;
  logic             empty_s;
  logic             full_s;
  logic             pop_fire_s;
  logic             push_fire_s;

  assign empty_s     = (cnt_q == '0);
  assign full_s      = (cnt_q == (AW+1)'(DEPTH));
  assign pop_fire_s  = pop_i & ~empty_s;
  // A pop frees the slot the same cycle, so a full FIFO still accepts.
  assign push_fire_s = push_i & (~full_s | pop_fire_s);
  assign drop_o      = push_i & ~push_fire_s;
  assign valid_o     = ~empty_s;
  assign data_o      = empty_s ? '0 : mem_q[rd_q];

  // Occupancy next-state.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_fire_s, pop_fire_s})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage, pointers and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_fire_s) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_fire_s) begin
        rd_q <= rd_q + AW'(1);
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/match_scoreboard.sv
// Best-of match scoreboard fed by the counter's GAMEOVER/who outputs:
// per-side round counters, match decision and a round-history FIFO.
module match_scoreboard
  import match_pkg::*;
#(
  parameter int unsigned ROUNDS_TO_WIN = 3,
  parameter int unsigned HIST_DEPTH    = 8,
  parameter int unsigned IDX_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             gameover_i,
  input  logic [1:0]       who_i,
  input  logic             clear_i,
  input  logic             hist_rd_i,
  output logic             hist_valid_o,
  output logic [IDX_W:0]   hist_data_o,
  output logic [3:0]       win_rounds_o,
  output logic [3:0]       lose_rounds_o,
  output logic             match_done_o,
  output logic [1:0]       match_who_o,
  output logic             overflow_o,
  output logic             proto_err_o
);

  localparam int unsigned HW  = hist_entry_w(IDX_W);
  localparam logic [3:0]  RTW = 4'(ROUNDS_TO_WIN);

  state_e           state_q, state_d;
  logic             go_q;
  logic [3:0]       win_q, win_d;
  logic [3:0]       lose_q, lose_d;
  logic             done_q, done_d;
  logic [1:0]       mwho_q, mwho_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ovf_q, ovf_d;
  logic             perr_q, perr_d;
  logic             evt_s;
  logic             push_s;
  logic [HW-1:0]    push_data_s;
  logic             drop_s;

  assign evt_s       = gameover_i & ~go_q;
  assign push_data_s = {idx_q, (who_i == WHO_WINNER)};
  assign ovf_d       = ovf_q | drop_s;

  // Match FSM, round counters, round index and protocol-error flag.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    lose_d  = lose_q;
    done_d  = done_q;
    mwho_d  = mwho_q;
    idx_d   = idx_q;
    perr_d  = perr_q;
    push_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // Clear takes priority; a coincident event is dropped entirely.
        if (clear_i) begin
          win_d  = 4'd0;
          lose_d = 4'd0;
        end else if (evt_s && who_is_valid(who_i)) begin
          push_s = 1'b1;
          idx_d  = idx_q + IDX_W'(1);
          if (who_i == WHO_WINNER) begin
            win_d = win_q + 4'd1;
            if (win_d == RTW) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              mwho_d  = WHO_WINNER;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            lose_d = lose_q + 4'd1;
            if (lose_d == RTW) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              mwho_d  = WHO_LOSER;
            end else begin
              state_d = S_RUN;
            end
          end
        end else if (evt_s) begin
          perr_d = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (clear_i) begin
          state_d = S_RUN;
          win_d   = 4'd0;
          lose_d  = 4'd0;
          done_d  = 1'b0;
          mwho_d  = WHO_NONE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and sticky-flag registers; gameover is sampled in every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      go_q    <= 1'b0;
      win_q   <= 4'd0;
      lose_q  <= 4'd0;
      done_q  <= 1'b0;
      mwho_q  <= WHO_NONE;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      go_q    <= gameover_i;
      win_q   <= win_d;
      lose_q  <= lose_d;
      done_q  <= done_d;
      mwho_q  <= mwho_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      perr_q  <= perr_d;
    end
  end

  hist_fifo #(
    .DEPTH (HIST_DEPTH),
    .WIDTH (HW)
  ) u_hist_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .data_i  (push_data_s),
    .pop_i   (hist_rd_i),
    .valid_o (hist_valid_o),
    .data_o  (hist_data_o),
    .drop_o  (drop_s)
  );

  assign win_rounds_o  = win_q;
  assign lose_rounds_o = lose_q;
  assign match_done_o  = done_q;
  assign match_who_o   = mwho_q;
  assign overflow_o    = ovf_q;
  assign proto_err_o   = perr_q;

endmodule

// File: tb/tb_match_scoreboard.sv
// Directed bench for match_scoreboard (ROUNDS_TO_WIN=3, HIST_DEPTH=4, IDX_W=4).
module tb_match_scoreboard;

  logic       clk;
  logic       rst;
  logic       enable_i;
  logic       gameover_i;
  logic [1:0] who_i;
  logic       clear_i;
  logic       hist_rd_i;
  logic       hist_valid_o;
  logic [4:0] hist_data_o;
  logic [3:0] win_rounds_o;
  logic [3:0] lose_rounds_o;
  logic       match_done_o;
  logic [1:0] match_who_o;
  logic       overflow_o;
  logic       proto_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  match_scoreboard #(
    .ROUNDS_TO_WIN (3),
    .HIST_DEPTH    (4),
    .IDX_W         (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable_i      (enable_i),
    .gameover_i    (gameover_i),
    .who_i         (who_i),
    .clear_i       (clear_i),
    .hist_rd_i     (hist_rd_i),
    .hist_valid_o  (hist_valid_o),
    .hist_data_o   (hist_data_o),
    .win_rounds_o  (win_rounds_o),
    .lose_rounds_o (lose_rounds_o),
    .match_done_o  (match_done_o),
    .match_who_o   (match_who_o),
    .overflow_o    (overflow_o),
    .proto_err_o   (proto_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [1:0] who, input int hold);
    gameover_i = 1'b1;
    who_i      = who;
    repeat (hold) step();
    gameover_i = 1'b0;
    step();
  endtask

  task automatic pop();
    hist_rd_i = 1'b1;
    step();
    hist_rd_i = 1'b0;
  endtask

  task automatic do_enable();
    enable_i = 1'b1;
    step();
    enable_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({hist_valid_o, hist_data_o, win_rounds_o, lose_rounds_o, match_done_o,
         match_who_o, overflow_o, proto_err_o} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%h w=%0d l=%0d done=%b who=%b ovf=%b perr=%b, expected all 0",
               hist_valid_o, hist_data_o, win_rounds_o, lose_rounds_o, match_done_o,
               match_who_o, overflow_o, proto_err_o);
    end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_first_round();
    do_enable();
    pulse(2'b10, 5);
    n_checks++;
    if (win_rounds_o !== 4'd1) begin
      n_fail++; $display("FAIL long_pulse_win: got %0d expected 1", win_rounds_o);
    end
    n_checks++;
    if (hist_valid_o !== 1'b1 || hist_data_o !== 5'b00001) begin
      n_fail++; $display("FAIL first_entry: got v=%b d=%b expected v=1 d=00001", hist_valid_o, hist_data_o);
    end
  endtask

  task automatic test_match();
    logic [4:0] exp_e [4];
    exp_e = '{5'b00001, 5'b00010, 5'b00101, 5'b00111};
    pulse(2'b01, 1);
    pulse(2'b10, 1);
    pulse(2'b10, 1);
    n_checks++;
    if (win_rounds_o !== 4'd3 || lose_rounds_o !== 4'd1) begin
      n_fail++; $display("FAIL match_counts: got w=%0d l=%0d expected w=3 l=1", win_rounds_o, lose_rounds_o);
    end
    n_checks++;
    if (match_done_o !== 1'b1 || match_who_o !== 2'b10) begin
      n_fail++; $display("FAIL match_decided: got done=%b who=%b expected done=1 who=10", match_done_o, match_who_o);
    end
    pulse(2'b01, 1);
    n_checks++;
    if (lose_rounds_o !== 4'd1 || win_rounds_o !== 4'd3 || proto_err_o !== 1'b0) begin
      n_fail++; $display("FAIL done_ignores: got w=%0d l=%0d perr=%b expected w=3 l=1 perr=0",
                         win_rounds_o, lose_rounds_o, proto_err_o);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (hist_valid_o !== 1'b1 || hist_data_o !== exp_e[i]) begin
        n_fail++; $display("FAIL match_hist[%0d]: got v=%b d=%b expected v=1 d=%b", i, hist_valid_o, hist_data_o, exp_e[i]);
      end
      pop();
    end
    n_checks++;
    if (hist_valid_o !== 1'b0 || hist_data_o !== 5'b00000) begin
      n_fail++; $display("FAIL match_hist_empty: got v=%b d=%b expected v=0 d=00000", hist_valid_o, hist_data_o);
    end
  endtask

  task automatic test_clear();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    n_checks++;
    if (match_done_o !== 1'b0 || match_who_o !== 2'b00 || win_rounds_o !== 4'd0 || lose_rounds_o !== 4'd0) begin
      n_fail++; $display("FAIL clear_done: got done=%b who=%b w=%0d l=%0d expected 0/00/0/0",
                         match_done_o, match_who_o, win_rounds_o, lose_rounds_o);
    end
    gameover_i = 1'b1;
    who_i      = 2'b10;
    clear_i    = 1'b1;
    step();
    clear_i = 1'b0;
    n_checks++;
    if (win_rounds_o !== 4'd0 || hist_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL clear_beats_event: got w=%0d v=%b expected w=0 v=0", win_rounds_o, hist_valid_o);
    end
    gameover_i = 1'b0;
    step();
    pulse(2'b01, 1);
    n_checks++;
    if (lose_rounds_o !== 4'd1 || hist_data_o !== 5'b01000) begin
      n_fail++; $display("FAIL idx_kept: got l=%0d d=%b expected l=1 d=01000", lose_rounds_o, hist_data_o);
    end
    pop();
  endtask

  task automatic test_proto();
    pulse(2'b00, 1);
    n_checks++;
    if (proto_err_o !== 1'b1 || win_rounds_o !== 4'd0 || lose_rounds_o !== 4'd1 || hist_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL proto_00: got perr=%b w=%0d l=%0d v=%b expected 1/0/1/0",
                         proto_err_o, win_rounds_o, lose_rounds_o, hist_valid_o);
    end
    pulse(2'b11, 1);
    n_checks++;
    if (proto_err_o !== 1'b1 || win_rounds_o !== 4'd0 || lose_rounds_o !== 4'd1 || hist_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL proto_11: got perr=%b w=%0d l=%0d v=%b expected 1/0/1/0",
                         proto_err_o, win_rounds_o, lose_rounds_o, hist_valid_o);
    end
  endtask

  task automatic test_async_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    do_enable();
    pulse(2'b10, 1);
    pulse(2'b01, 1);
    pulse(2'b10, 1);
    n_checks++;
    if (win_rounds_o !== 4'd2 || lose_rounds_o !== 4'd1 || hist_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: got w=%0d l=%0d v=%b expected 2/1/1", win_rounds_o, lose_rounds_o, hist_valid_o);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({hist_valid_o, hist_data_o, win_rounds_o, lose_rounds_o, match_done_o,
         match_who_o, overflow_o, proto_err_o} !== 19'd0) begin
      n_fail++; $display("FAIL async_reset: got v=%b d=%h w=%0d l=%0d, expected all 0",
                         hist_valid_o, hist_data_o, win_rounds_o, lose_rounds_o);
    end
    step();
    rst = 1'b1;
    step();
    pulse(2'b10, 1);
    n_checks++;
    if (win_rounds_o !== 4'd0 || hist_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL idle_ignores: got w=%0d v=%b expected w=0 v=0", win_rounds_o, hist_valid_o);
    end
  endtask

  task automatic test_overflow();
    logic [4:0] exp_e [4];
    exp_e = '{5'b00010, 5'b00101, 5'b00110, 5'b01101};
    do_enable();
    pulse(2'b10, 1);
    pulse(2'b01, 1);
    pulse(2'b10, 1);
    pulse(2'b01, 1);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    pulse(2'b10, 1);
    pulse(2'b01, 1);
    n_checks++;
    if (overflow_o !== 1'b1 || hist_data_o !== 5'b00001 || win_rounds_o !== 4'd1 || lose_rounds_o !== 4'd1) begin
      n_fail++; $display("FAIL overflow: got ovf=%b d=%b w=%0d l=%0d expected 1/00001/1/1",
                         overflow_o, hist_data_o, win_rounds_o, lose_rounds_o);
    end
    gameover_i = 1'b1;
    who_i      = 2'b10;
    hist_rd_i  = 1'b1;
    step();
    hist_rd_i  = 1'b0;
    gameover_i = 1'b0;
    step();
    n_checks++;
    if (win_rounds_o !== 4'd2 || overflow_o !== 1'b1) begin
      n_fail++; $display("FAIL full_push_pop: got w=%0d ovf=%b expected w=2 ovf=1", win_rounds_o, overflow_o);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (hist_valid_o !== 1'b1 || hist_data_o !== exp_e[i]) begin
        n_fail++; $display("FAIL ovf_hist[%0d]: got v=%b d=%b expected v=1 d=%b", i, hist_valid_o, hist_data_o, exp_e[i]);
      end
      pop();
    end
    n_checks++;
    if (hist_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL ovf_hist_empty: got v=%b expected 0", hist_valid_o);
    end
  endtask

  initial begin
    enable_i   = 1'b0;
    gameover_i = 1'b0;
    who_i      = 2'b00;
    clear_i    = 1'b0;
    hist_rd_i  = 1'b0;
    test_reset();
    test_first_round();
    test_match();
    test_clear();
    test_proto();
    test_async_reset();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/match_scoreboard.md
Name: match_scoreboard

Overview:
- Sits directly downstream of the multi-mode counter; consumes its GAMEOVER/who round-result outputs.
- Counts round wins per side, declares a best-of match winner once a side reaches ROUNDS_TO_WIN, and logs every round result in a show-ahead history FIFO.
- The FIFO is drained by a host/display stage through a valid/read handshake.

Parameters:
- ROUNDS_TO_WIN, 3, round wins needed to end a match (1..15)
- HIST_DEPTH, 8, history FIFO entries (power of 2, >=2)
- IDX_W, 4, width of the round index stored per history entry

Ports:
- clk  input  1  clock, all state on posedge
- rst  input  1  reset, asynchronous, active-low
- enable_i  input  1  leave IDLE and start accepting rounds
- gameover_i  input  1  round-end flag from counter (level, may be high >1 cycle)
- who_i  input  2  round result from counter: 2'b10 winner side, 2'b01 loser side
- clear_i  input  1  start a new match (round counters cleared, history kept)
- hist_rd_i  input  1  pop history head
- hist_valid_o  output  1  history non-empty
- hist_data_o  output  IDX_W+1  head entry {round_idx, result}; result 1=winner side, 0=loser side
- win_rounds_o  output  4  rounds won by winner side this match
- lose_rounds_o  output  4  rounds won by loser side this match
- match_done_o  output  1  match decided
- match_who_o  output  2  2'b10 winner side took match, 2'b01 loser side, 2'b00 undecided
- overflow_o  output  1  sticky: a round was dropped because history was full
- proto_err_o  output  1  sticky: gameover rise with who_i of 2'b00 or 2'b11

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; FIFO empty; round_idx=0; gameover edge register=0.
- Round event = registered rising edge of gameover_i (gameover_i=1 and previous-cycle sample=0); a long-high gameover counts once.
- who_i is sampled in the same cycle as the rising edge.
- FSM:
  - IDLE: events ignored; enable_i=1 -> RUN next cycle.
  - RUN: on a valid event, the decided side's counter increments at the next posedge.
    - If the new value equals ROUNDS_TO_WIN -> DONE, with match_done_o=1 and match_who_o set in that same cycle as the counter update.
    - clear_i in RUN zeroes both counters; state stays RUN.
  - DONE: events ignored (no count, no history push, no error).
    - clear_i -> RUN; counters, match_done_o and match_who_o cleared next cycle.
- Priority in RUN when clear_i and an event coincide: clear wins and the event is discarded entirely.
- Invalid who_i (00/11) on an event: proto_err_o set (sticky until reset); counters untouched; no push.
- Valid event in RUN pushes {round_idx, who_i==2'b10} into the FIFO. round_idx then increments, wrapping modulo 2^IDX_W; it is never cleared by clear_i.
- History FIFO:
  - show-ahead: hist_data_o valid whenever hist_valid_o=1; hist_data_o=0 when empty.
  - Pop occurs on hist_rd_i & hist_valid_o; a read while empty is a no-op.
  - Push when full and no pop in the same cycle: entry dropped, overflow_o set (sticky), round_idx still increments.
  - Push + pop in the same cycle: both succeed, occupancy unchanged, including the full case.
  - Push into an empty FIFO: visible (hist_valid_o=1) the cycle after the push edge.
- Reset mid-operation: immediate return to the reset state; FIFO contents lost.
- Counters are 4 bits and saturate logically at ROUNDS_TO_WIN, since DONE blocks further increments.

Decomposition:
- Package match_pkg:
  - who encodings WHO_NONE=2'b00, WHO_LOSER=2'b01, WHO_WINNER=2'b10
  - state enum {S_IDLE, S_RUN, S_DONE}
  - history entry width helper
- Sub-module hist_fifo (parameterised depth/width, show-ahead, full/empty, simultaneous push/pop), instantiated once.

Test Plan:
- Reset then enable_i=1, a gameover_i pulse held 5 cycles with who_i=10 -> win_rounds_o=1 exactly, hist_data_o={0,1}, hist_valid_o=1.
- Alternate results 10,01,10,10 -> win_rounds_o=3, lose_rounds_o=1, match_done_o=1, match_who_o=10; a fifth pulse is ignored, FIFO holds 4 entries with idx 0..3.
- clear_i coincident with a gameover rise in RUN -> counters 0, no push, round_idx unchanged; a later clear_i in DONE -> match_done_o=0 and match_who_o=00 next cycle.
- HIST_DEPTH=4, six events with no reads -> 4 entries idx 0..3, overflow_o=1; next push with a simultaneous pop is accepted, and the stored idx is 6.
- gameover rise with who_i=00 and with who_i=11 -> proto_err_o=1, counters and FIFO unchanged; events while in IDLE are also ignored.
- Assert rst low mid-match with 3 entries stored -> all outputs 0 asynchronously (before the next clk edge); after release, state is IDLE.
